// File: rtl/and_gate_design.sv
// Bitwise AND gate with a registered output copy, sticky per-bit truth-table
// coverage and a saturating counter of all-ones output cycles.
module and_gate_design #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     Y,
    output logic [WIDTH-1:0]     Y_q,
    output logic [4*WIDTH-1:0]   COV,
    output logic                 ALL_COV,
    output logic [CNT_W-1:0]     HIT_CNT
);

    logic [WIDTH-1:0]   r_y_p1;
    logic [4*WIDTH-1:0] r_cov_p1;
    logic [CNT_W-1:0]   r_hit_cnt_p1;
    logic [4*WIDTH-1:0] w_cov_set;
    logic               w_all_ones;

    // Holds at the top code instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + CNT_W'(1);
    endfunction

    assign Y          = A & B;
    assign w_all_ones = &Y;

    // One-hot per bit: selects the truth-table row {A[i],B[i]} seen this cycle.
    always_comb begin
        w_cov_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cov_set[4*i + int'({A[i], B[i]})] = 1'b1;
        end
    end

    // Stage p1: registered copies sampled on the rising edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_p1       <= '0;
            r_cov_p1     <= '0;
            r_hit_cnt_p1 <= '0;
        end else begin
            r_y_p1   <= Y;
            r_cov_p1 <= r_cov_p1 | w_cov_set;
            if (w_all_ones)
                r_hit_cnt_p1 <= sat_inc(r_hit_cnt_p1);
        end
    end

    assign Y_q     = r_y_p1;
    assign COV     = r_cov_p1;
    assign ALL_COV = &r_cov_p1;
    assign HIT_CNT = r_hit_cnt_p1;

endmodule

// File: tb/tb_and_gate_design.sv
// Self-checking bench: a 1-bit and a 4-bit instance compared against a
// truth-table based reference model under directed and random stimulus.
module tb_and_gate_design;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a1, b1, y1, yq1, all1;
    logic [3:0] cov1;
    logic [7:0] hit1;
    logic [3:0] a4, b4, y4, yq4;
    logic [15:0] cov4;
    logic       all4;
    logic [7:0] hit4;

    and_gate_design #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Y(y1), .Y_q(yq1),
        .COV(cov1), .ALL_COV(all1), .HIT_CNT(hit1)
    );

    and_gate_design #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Y(y4), .Y_q(yq4),
        .COV(cov4), .ALL_COV(all4), .HIT_CNT(hit4)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: truth table rows 00,01,10,11 and sets of rows seen.
    bit   TT[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit   seen1[4];
    bit   seen4[4][4];
    int   cnt1, cnt4;
    logic yq1_m;
    logic [3:0] yq4_m;
    logic [3:0] seq_cov[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    function automatic logic [3:0] ref_y4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = TT[2*int'(a[i]) + int'(b[i])];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                seen1[p] = 1'b0;
                for (int i = 0; i < 4; i++) seen4[i][p] = 1'b0;
            end
            cnt1 = 0; cnt4 = 0; yq1_m = 1'b0; yq4_m = 4'h0;
        end else begin
            yq1_m = TT[2*int'(a1) + int'(b1)];
            seen1[2*int'(a1) + int'(b1)] = 1'b1;
            if (yq1_m && cnt1 < 255) cnt1++;
            yq4_m = ref_y4(a4, b4);
            for (int i = 0; i < 4; i++) seen4[i][2*int'(a4[i]) + int'(b4[i])] = 1'b1;
            if (yq4_m == 4'hF && cnt4 < 255) cnt4++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        logic [3:0]  c1;
        logic [15:0] c4;
        logic        f1, f4;
        f1 = 1'b1; f4 = 1'b1;
        for (int p = 0; p < 4; p++) begin
            c1[p] = seen1[p];
            f1 &= seen1[p];
            for (int i = 0; i < 4; i++) begin
                c4[4*i + p] = seen4[i][p];
                f4 &= seen4[i][p];
            end
        end
        chk("y1",    64'(y1),    64'(TT[2*int'(a1) + int'(b1)]));
        chk("yq1",   64'(yq1),   64'(yq1_m));
        chk("cov1",  64'(cov1),  64'(c1));
        chk("all1",  64'(all1),  64'(f1));
        chk("hit1",  64'(hit1),  64'(cnt1));
        chk("y4",    64'(y4),    64'(ref_y4(a4, b4)));
        chk("yq4",   64'(yq4),   64'(yq4_m));
        chk("cov4",  64'(cov4),  64'(c4));
        chk("all4",  64'(all4),  64'(f4));
        chk("hit4",  64'(hit4),  64'(cnt4));
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;

        // Combinational truth table, exercised while reset is held
        for (int k = 0; k < 4; k++) begin
            a1 = k[1]; b1 = k[0];
            #5;
            chk("t1_y_in_reset", 64'(y1), 64'(k == 3));
        end
        a1 = 1'b0; b1 = 1'b0;
        tick();
        tick();
        chk("rst_yq", 64'(yq1), 64'd0);
        chk("rst_cov", 64'(cov1), 64'd0);
        chk("rst_all", 64'(all1), 64'd0);
        chk("rst_hit", 64'(hit1), 64'd0);
        check_all();

        // Four vectors, one per clock: coverage fills up row by row
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a1 = k[1]; b1 = k[0];
            #1;
            chk("t2_y", 64'(y1), 64'(k == 3));
            tick();
            chk("t2_yq", 64'(yq1), 64'(k == 3));
            chk("t2_cov", 64'(cov1), 64'(seq_cov[k]));
            chk("t2_all", 64'(all1), 64'(k == 3));
            check_all();
        end

        // Saturation of the hit counter
        a1 = 1'b1; b1 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            check_all();
        end
        chk("t3_hit_sat", 64'(hit1), 64'd255);
        a1 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_all();
        end
        chk("t3_hit_hold", 64'(hit1), 64'd255);

        // Reset after full coverage, with A=B=1 on the inputs
        a1 = 1'b1; b1 = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("t4_cov", 64'(cov1), 64'd0);
        chk("t4_all", 64'(all1), 64'd0);
        chk("t4_hit", 64'(hit1), 64'd0);
        chk("t4_yq", 64'(yq1), 64'd0);
        chk("t4_y", 64'(y1), 64'd1);
        check_all();
        rst_n = 1'b1;

        // Wide instance: one distinct truth-table row per bit
        a1 = 1'b0; b1 = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        chk("t5_y", 64'(y4), 64'(4'b1000));
        tick();
        chk("t5_yq", 64'(yq4), 64'(4'b1000));
        chk("t5_hit", 64'(hit4), 64'd0);
        chk("t5_cov", 64'(cov4), 64'(16'b1000_0100_0010_0001));
        check_all();

        // Inputs meet at 1/1 only between edges
        a1 = 1'b1; b1 = 1'b0;
        #2;
        chk("t6_y_a", 64'(y1), 64'd0);
        b1 = 1'b1;
        #2;
        chk("t6_y_glitch", 64'(y1), 64'd1);
        a1 = 1'b0;
        #2;
        chk("t6_y_b", 64'(y1), 64'd0);
        tick();
        chk("t6_yq", 64'(yq1), 64'd0);
        chk("t6_hit", 64'(hit1), 64'd0);
        check_all();

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 3) == 0) begin
                a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
            end else begin
                a4 = 4'($urandom); b4 = 4'($urandom);
                a1 = 1'($urandom); b1 = 1'($urandom);
            end
            #1;
            chk("rnd_y4", 64'(y4), 64'(ref_y4(a4, b4)));
            tick();
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
